// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, LSB first, mid-bit sampling.
// The rx line is synchronised through two flops; every decision uses the
// synchronised copy. Each completed frame updates rx_data, framing_error
// and parity_error together with a one-cycle rx_done strobe.
// Optional feature: define UART_RX_PARITY_EN to receive one even-parity
// bit between the data bits and the stop bit (8E1 framing).
module uart_rx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_busy,
  output logic       framing_error,
  output logic       parity_error
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
`ifdef UART_RX_PARITY_EN
    ,
    S_PARITY    = 3'd5
`endif
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_sync1;
  logic             r_sync2;
  logic             w_rx_s;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             w_half;
  logic             w_full;
  logic             w_shift_en;
  logic             w_done;
  logic [7:0]       r_rx_data;
  logic             r_rx_done;
  logic             r_framing_error;

  assign w_rx_s = r_sync2;
  assign w_half = (r_cnt == CNT_W'(HALF_BIT - 1));
  assign w_full = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments here so r_sync2 takes the old r_sync1,
      // giving two real flop stages instead of one collapsed wire.
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state decode and the per-cycle datapath strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves one unassigned and infers a latch.
    w_state_next = r_state;
    w_shift_en   = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rx_s) w_state_next = S_START;
      end
      S_START: begin
        // Mid start bit: still low means a real frame, high means a glitch.
        if (w_half) w_state_next = w_rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (w_full) begin
          w_shift_en = 1'b1;
`ifdef UART_RX_PARITY_EN
          if (r_bit_idx == 3'd7) w_state_next = S_PARITY;
`else
          if (r_bit_idx == 3'd7) w_state_next = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_full) w_state_next = S_STOP;
      end
`endif
      S_STOP: begin
        if (w_full) begin
          w_done       = 1'b1;
          // A low stop bit may be the start of a break; wait for idle first.
          w_state_next = w_rx_s ? S_IDLE : S_WAIT_HIGH;
        end
      end
      S_WAIT_HIGH: begin
        if (w_rx_s) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Baud counter: cleared on every state change, in IDLE and at each bit end.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if ((w_state_next != r_state) || (r_state == S_IDLE) || w_full) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Bit index and shift register; first bit received ends up in bit 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
    end else begin
      if (w_state_next != r_state) r_bit_idx <= 3'd0;
      else if (w_shift_en)         r_bit_idx <= r_bit_idx + 3'd1;
      if (w_shift_en) r_shift <= {w_rx_s, r_shift[7:1]};
    end
  end

  // Frame results, all registered in the stop-bit sample cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_data       <= 8'h00;
      r_rx_done       <= 1'b0;
      r_framing_error <= 1'b0;
    end else begin
      r_rx_done <= w_done;
      if (w_done) begin
        r_rx_data       <= r_shift;
        r_framing_error <= ~w_rx_s;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_bit;
  logic r_parity_error;

  // Capture the parity bit mid-bit, then check even parity with rx_done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_par_bit      <= 1'b0;
      r_parity_error <= 1'b0;
    end else begin
      if ((r_state == S_PARITY) && w_full) r_par_bit <= w_rx_s;
      if (w_done) r_parity_error <= (^r_shift) ^ r_par_bit;
    end
  end

  assign parity_error = r_parity_error;
`else
  assign parity_error = 1'b0;
`endif

  assign rx_data       = r_rx_data;
  assign rx_done       = r_rx_done;
  assign framing_error = r_framing_error;
  assign rx_busy       = (r_state != S_IDLE);

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver, 8N1 (8 data bits, no parity, 1 stop bit), LSB first. Sits downstream of uart_tx: it consumes the `tx` line and recovers bytes.
- Default operating point is 9600 baud from the 50 MHz system clock.
- Each received byte is presented on `rx_data` with a one-cycle `rx_done` strobe, plus a framing-error flag.
- Used for loopback checks against uart_tx and as the board's serial input stage.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD_RATE, 9600, line bit rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD_RATE (5208), clocks per bit; derived localparam using integer division.
- HALF_BIT, CLKS_PER_BIT/2 (2604), derived localparam.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx  input  1  serial line; idles high; asynchronous to clk.
- rx_data  output  8  last received byte; holds until the next frame completes.
- rx_done  output  1  one-cycle pulse when a frame completes.
- rx_busy  output  1  high whenever the FSM is not in IDLE.
- framing_error  output  1  stop bit of the last frame sampled 0; updated with rx_done.
- parity_error  output  1  see Optional Feature; tied 0 when the feature is absent.

Behaviour:
- Single clock; reset is asynchronous and active-low.
- Reset values:
  - rx_data=0, rx_done=0, framing_error=0, parity_error=0, rx_busy=0.
  - Both synchronizer flops=1; counters=0; state=IDLE.
- Synchronizer: rx passes through 2 flops to give rx_s. All decisions use rx_s only.
- Baud counter: counts 0..CLKS_PER_BIT-1 and clears on every state change. Bit counter is 3 bits, 0..7.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH (plus PARITY when the feature is enabled).
  - IDLE: if rx_s=0, go to START with counter cleared.
  - START: at counter=HALF_BIT-1, sample rx_s.
    - rx_s=0: go to DATA with counter and bit index cleared.
    - rx_s=1: treat as a glitch and return to IDLE. No outputs change.
  - DATA: at counter=CLKS_PER_BIT-1, shift rx_s into the shift register MSB (shift right, so the first bit lands at bit 0).
    - After bit index 7, go to STOP; otherwise increment the bit index.
  - STOP: at counter=CLKS_PER_BIT-1, in the same cycle:
    - rx_data <= shift register.
    - framing_error <= ~rx_s.
    - rx_done <= 1.
    - Next state: IDLE if rx_s=1; WAIT_HIGH if rx_s=0.
  - WAIT_HIGH: stay until rx_s=1, then go to IDLE. A held-low line (break) never generates repeated frames.
- rx_done is high for exactly one clock per frame, and only for frames whose start bit was validated.
- Latency: rx_done rises 2 + HALF_BIT + 9*CLKS_PER_BIT clocks (±1) after the rx falling edge of the start bit.
- Back-to-back frames: the next start edge may arrive immediately after the stop mid-sample. IDLE re-arms in the cycle after STOP, so no frame is lost at full line rate.
- Reset mid-frame: the partial frame is discarded and all outputs return to their reset values.
  - After reset release, the first falling edge starts a new frame.
  - A line already low at release is treated as a start edge (the bench must release reset with rx high).
- rx_data and framing_error are stable between rx_done pulses.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - After DATA, the FSM enters PARITY and samples one extra bit at mid-bit.
  - Even parity is expected.
  - parity_error <= (XOR of the 8 data bits) ^ parity bit, registered with rx_done.
  - Latency grows by CLKS_PER_BIT.
  - The paired uart_tx must also send parity.
- Not defined:
  - No PARITY state; frame is 8N1.
  - parity_error is constant 0.

Test Plan:
- Loopback: uart_tx.tx -> rx, send 8'hA5.
  - rx_done pulses once for 1 clk.
  - rx_data=8'hA5, framing_error=0.
  - Pulse occurs 2+2604+9*5208 clks (±1) after the start edge.
- Sweep: send 0x00..0xFF back-to-back via uart_tx.
  - 256 rx_done pulses.
  - Each rx_data equals the sent byte; zero framing errors.
- Glitch: drive rx low for 1000 clks, then high.
  - No rx_done; rx_busy returns to 0 within HALF_BIT+3 clks of the low edge.
- Framing: bench drives 8'h3C with stop bit 0, then holds rx low for 3 bit times, then high.
  - One rx_done with rx_data=8'h3C and framing_error=1.
  - No further rx_done until after rx goes high.
- Reset mid-frame: assert reset during bit 4 of 8'hFF, release with rx high, then send 8'h5A.
  - Outputs are 0 during reset.
  - Only one rx_done follows, with rx_data=8'h5A.
- With UART_RX_PARITY_EN: send 8'h07 with parity bit 1 (correct even parity) -> parity_error=0. Send it with parity bit 0 -> parity_error=1.
